// File: rtl/io_byte_loader.sv
// Pad-side byte loader: synchronizes a strobed 8-bit pad bus, pairs bytes into
// 16-bit words and buffers them in a small FIFO with a valid/ready output.
module io_byte_loader #(
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_n,
  input  logic [7:0]               pad_data_i,
  input  logic                     pad_strb_i,
  output logic                     pad_ack_o,
  output logic [15:0]              word_o,
  output logic                     word_valid_o,
  input  logic                     word_ready_i,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     overflow_o,
  input  logic                     clr_i
);

  localparam int            AW      = $clog2(DEPTH);
  localparam logic [AW:0]   PTR_ONE = 1;

  logic [SYNC_STAGES-1:0][7:0] r_data_sync;
  logic [SYNC_STAGES-1:0]      r_strb_sync;
  logic                        r_strb_d;
  logic                        r_phase;
  logic [7:0]                  r_low;
  logic                        r_ack;
  logic                        r_overflow;
  logic [AW:0]                 r_wr_ptr;
  logic [AW:0]                 r_rd_ptr;
  logic [15:0]                 r_mem [DEPTH];

  logic       w_edge;
  logic       w_cap;
  logic [7:0] w_byte;
  logic       w_push_req;
  logic       w_empty;
  logic       w_full;
  logic       w_pop;
  logic       w_push;
  logic       w_drop;

  // The synchronizers keep running through clr_i so the strobe edge history stays valid.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      r_data_sync <= '0;
      r_strb_sync <= '0;
      r_strb_d    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let every stage sample the previous stage's old value.
      r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], pad_data_i};
      r_strb_sync <= {r_strb_sync[SYNC_STAGES-2:0], pad_strb_i};
      r_strb_d    <= r_strb_sync[SYNC_STAGES-1];
    end
  end

  assign w_edge     = r_strb_sync[SYNC_STAGES-1] & ~r_strb_d;
  assign w_byte     = r_data_sync[SYNC_STAGES-1];
  assign w_cap      = w_edge & ~clr_i;
  assign w_push_req = w_cap & r_phase;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop   = ~w_empty & word_ready_i & ~clr_i;
  assign w_push  = w_push_req & (~w_full | w_pop);
  assign w_drop  = w_push_req & w_full & ~w_pop;

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      r_phase    <= 1'b0;
      r_low      <= 8'h00;
      r_ack      <= 1'b0;
      r_overflow <= 1'b0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
    end else begin
      if (w_cap) begin
        r_ack <= ~r_ack;
      end
      if (clr_i) begin
        r_phase    <= 1'b0;
        r_low      <= 8'h00;
        r_overflow <= 1'b0;
        r_wr_ptr   <= '0;
        r_rd_ptr   <= '0;
      end else begin
        if (w_cap) begin
          r_phase <= ~r_phase;
          if (!r_phase) begin
            r_low <= w_byte;
          end
        end
        if (w_drop) begin
          r_overflow <= 1'b1;
        end
        if (w_push) begin
          r_wr_ptr <= r_wr_ptr + PTR_ONE;
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + PTR_ONE;
        end
      end
    end
  end

  // NOTE: the storage is reset because word_o reads it directly and must be 0 out of reset.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= 16'h0000;
      end
    end else if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= {w_byte, r_low};
    end
  end

  assign pad_ack_o    = r_ack;
  assign word_o       = r_mem[r_rd_ptr[AW-1:0]];
  assign word_valid_o = ~w_empty;
  assign level_o      = r_wr_ptr - r_rd_ptr;
  assign overflow_o   = r_overflow;

endmodule

// File: doc/io_byte_loader.md
# io_byte_loader

Input-side loader that sits directly upstream of the mips8 core (`user_proj_example`) and feeds it instruction and data words from the pads. It synchronizes an 8-bit pad bus and a strobe pin into the core clock domain and assembles byte pairs into 16-bit words. Words are buffered in a small FIFO and presented to the core over a valid/ready handshake. A sticky overflow flag records words lost when the FIFO is full.

## Interface
- DEPTH, 4: FIFO depth in 16-bit words; power of two, ≥2.
- SYNC_STAGES, 2: synchronizer flops on pad inputs; ≥2.

- wb_clk_i  in  1  core clock; all logic on rising edge.
- wb_rst_n  in  1  reset, asynchronous assert, active-low; synchronous deassert is provided externally.
- pad_data_i  in  8  pad byte bus (io_in[12:5]); asynchronous.
- pad_strb_i  in  1  pad byte strobe; rising edge marks a valid byte; asynchronous.
- pad_ack_o  out  1  toggles once per captured byte, for host pacing.
- word_o  out  16  FIFO head word; bits [7:0] first byte, [15:8] second byte.
- word_valid_o  out  1  FIFO non-empty.
- word_ready_i  in  1  core accepts head word when high with word_valid_o.
- level_o  out  $clog2(DEPTH)+1  current FIFO occupancy, 0..DEPTH.
- overflow_o  out  1  sticky: a completed word was dropped.
- clr_i  in  1  synchronous flush.

## Operation
- pad_data_i and pad_strb_i each pass through SYNC_STAGES flops. Edge detect is sync_strb & ~strb_d, with strb_d one extra flop.
- On a detected edge, the synchronized byte is captured:
  - phase=0: the byte goes to the low hold register; phase←1.
  - phase=1: word {byte, low} is pushed; phase←0.
- pad_ack_o toggles on every detected edge, including bytes of a dropped word.
- Push when the FIFO is full and there is no pop in the same cycle: the word is discarded, overflow_o←1, FIFO contents unchanged.
- Pop occurs when word_valid_o & word_ready_i. The read pointer advances and word_o shows the next entry in the following cycle.
- Simultaneous push and pop:
  - Always legal, including when full; level is unchanged.
  - When empty, the pop is impossible, so only the push takes effect.
- Pointers are $clog2(DEPTH)+1 bits wide and wrap modulo 2·DEPTH.
  - Full when MSBs differ and the rest are equal.
  - Empty when the pointers are equal.
- clr_i takes priority over push, pop and edge capture in its cycle. It empties the FIFO and clears phase, the low hold register and overflow_o. pad_ack_o keeps its value.
- overflow_o clears only on clr_i or reset.
- No fall-through: word_o is driven from the FIFO storage at the read pointer.

## Timing
- Reset values: pad_ack_o=0, word_o=0, word_valid_o=0, level_o=0, overflow_o=0; internal phase=0 and pointers=0. Synchronizer flops also reset to 0.
- Host constraints:
  - pad_data_i must be stable from SYNC_STAGES+2 cycles before until SYNC_STAGES+2 cycles after the strobe rising edge.
  - pad_strb_i must hold high and low for ≥ SYNC_STAGES+1 cycles each.
- Latency: for the second byte, strobe rise to word_valid_o high is SYNC_STAGES+1 rising edges; the push is registered on the last of these.
- pad_ack_o toggle: visible SYNC_STAGES+1 edges after the strobe rise.
- Throughput: one pop per cycle. Pushes are limited by the strobe timing, at most one word per 2·(2·SYNC_STAGES+2) cycles.
- Reset mid-operation: immediate asynchronous return to reset values. A half-assembled word is lost, and the next byte is treated as a low byte.

## Test plan
- Single word:
  - Stimulus: reset, then bytes 0x34 then 0x12 with word_ready_i=0.
  - Response: word_o=0x1234, word_valid_o=1 and level_o=1 exactly SYNC_STAGES+1 edges after the second strobe rise; pad_ack_o toggled twice.
- Fill and overflow:
  - Stimulus: DEPTH=4, ready=0, five words 0x0101..0x0505.
  - Response: level_o=4 and overflow_o=1 after the fifth; draining yields 0x0101..0x0404 in order, then word_valid_o=0.
- Push and pop when full:
  - Stimulus: FIFO full, hold word_ready_i=1 in the cycle the sixth word's push lands.
  - Response: overflow_o stays 0, level_o stays 4, and the new word appears last on drain.
- Wrap-around:
  - Stimulus: stream 10 words through with ready=1 continuously.
  - Response: all 10 received in order, level_o never exceeds 1, no overflow.
- clr_i mid-word:
  - Stimulus: send 0xAA, pulse clr_i, then send 0x11, 0x22.
  - Response: single word 0x2211, level_o=1, overflow_o=0.
- Async reset mid-operation:
  - Stimulus: with two words buffered and overflow_o=1, assert wb_rst_n low mid-cycle.
  - Response: all outputs are 0 before the next clock edge and stay 0 after release until new bytes arrive.
